enc_reg: RTL and testbench

Registered 4-to-2 priority encoder with request latching and a valid/ack handshake; it is the encoding counterpart to the team's 2-to-4 decoder (`dec`). It captures one-hot or multi-hot request lines while enabled and holds them as sticky pending bits. It then presents the highest-priority pending index as a 2-bit code and holds that code until the consumer acknowledges it. It sits between the request sources and any block that consumes a binary index, e.g. a `dec` driven from `code`/`valid`.

---
 rtl/enc_reg_pkg.sv | 18 +
 rtl/enc_reg_prio_enc4.sv | 21 ++
 rtl/enc_reg.sv | 77 +++++++
 tb/tb_enc_reg.sv | 131 +++++++++++++
 4 files changed

// File: rtl/enc_reg_pkg.sv
// Shared constants for the registered priority encoder: sizes, FSM state codes
// and a one-hot helper used to retire a granted pending bit.
package enc_reg_pkg;

  localparam int N = 4;
  localparam int W = 2;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_HOLD = 1'b1;

  function automatic logic [N-1:0] onehot(input logic [W-1:0] idx);
    logic [N-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/enc_reg_prio_enc4.sv
// Combinational 4-to-2 encoder, highest index wins; zero latency, no flow control.
// any=0 means no bit set, and idx is then 0.
import enc_reg_pkg::*;

module prio_enc4 (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         any
);

  always_comb begin
    idx = 2'd0;
    any = 1'b1;
    if (req[3])      idx = 2'd3;
    else if (req[2]) idx = 2'd2;
    else if (req[1]) idx = 2'd1;
    else if (req[0]) idx = 2'd0;
    else             any = 1'b0;
  end

endmodule

// File: rtl/enc_reg.sv
// Sticky request capture feeding a held priority grant; request-to-valid 2 cycles.
// Backpressure: the granted code is held until ack, with one IDLE cycle between grants.
import enc_reg_pkg::*;

module enc_reg (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] req,
  input  logic         ack,
  output logic [W-1:0] code,
  output logic         valid,
  output logic [N-1:0] pending
);

  logic         state_q, state_d;
  logic [N-1:0] pending_q, pending_d;
  logic [W-1:0] code_q, code_d;
  logic         valid_q, valid_d;

  logic [W-1:0] enc_idx;
  logic         enc_any;
  logic [N-1:0] clear;

  // Encoding the registered pending bits, not raw req, keeps outputs free of input paths.
  prio_enc4 u_prio (
    .req (pending_q),
    .idx (enc_idx),
    .any (enc_any)
  );

  always_comb begin
    clear     = '0;
    state_d   = state_q;
    code_d    = code_q;
    valid_d   = valid_q;

    if (state_q == ST_HOLD && ack) clear = onehot(code_q);
    // OR-ing the set after the clear lets a re-request during ack re-arm the bit.
    pending_d = (pending_q & ~clear) | (en ? req : '0);

    case (state_q)
      ST_IDLE: begin
        if (enc_any) begin
          code_d  = enc_idx;
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end
      end
      default: begin
        if (ack) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
    end
  end

  assign code    = code_q;
  assign valid   = valid_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_enc_reg.sv
// Directed bench for enc_reg: hand-computed expectations checked after each edge.
module tb_enc_reg;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] req;
  logic       ack;
  logic [1:0] code;
  logic       valid;
  logic [3:0] pending;

  int checks = 0;
  int errors = 0;

  enc_reg dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .req     (req),
    .ack     (ack),
    .code    (code),
    .valid   (valid),
    .pending (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] p, input logic v, input logic [1:0] c);
    chk({tag, ".pending"}, pending, p);
    chk({tag, ".valid"}, {3'b000, valid}, {3'b000, v});
    chk({tag, ".code"}, {2'b00, code}, {2'b00, c});
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; req = 4'b0000; ack = 1'b0;
    step();
    step();
    chk_all("reset", 4'b0000, 1'b0, 2'b00);

    // capture disabled
    rst = 1'b0; en = 1'b0; req = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("en_off", 4'b0000, 1'b0, 2'b00);
    end

    // single request, latency and hold
    en = 1'b1; req = 4'b0100;
    step(); chk_all("single_cap", 4'b0100, 1'b0, 2'b00);
    req = 4'b0000;
    step(); chk_all("single_grant", 4'b0100, 1'b1, 2'b10);
    step(); chk_all("single_hold", 4'b0100, 1'b1, 2'b10);
    ack = 1'b1;
    step(); chk_all("single_ack", 4'b0000, 1'b0, 2'b10);
    ack = 1'b0;
    step(); chk_all("single_idle", 4'b0000, 1'b0, 2'b10);

    // multi-hot: order 11, 01, (late 11), 00
    req = 4'b1011;
    step(); chk_all("multi_cap", 4'b1011, 1'b0, 2'b10);
    req = 4'b0000;
    step(); chk_all("multi_g3", 4'b1011, 1'b1, 2'b11);
    ack = 1'b1;
    step(); chk_all("multi_a3", 4'b0011, 1'b0, 2'b11);
    ack = 1'b0;
    step(); chk_all("multi_g1", 4'b0011, 1'b1, 2'b01);
    req = 4'b1000;
    step(); chk_all("nopreempt", 4'b1011, 1'b1, 2'b01);
    req = 4'b0000;
    step(); chk_all("nopreempt2", 4'b1011, 1'b1, 2'b01);
    ack = 1'b1;
    step(); chk_all("multi_a1", 4'b1001, 1'b0, 2'b01);
    ack = 1'b0;
    step(); chk_all("late_g3", 4'b1001, 1'b1, 2'b11);
    ack = 1'b1;
    step(); chk_all("late_a3", 4'b0001, 1'b0, 2'b11);
    ack = 1'b0;
    step(); chk_all("multi_g0", 4'b0001, 1'b1, 2'b00);
    ack = 1'b1;
    step(); chk_all("multi_a0", 4'b0000, 1'b0, 2'b00);
    ack = 1'b0;
    step(); chk_all("multi_done", 4'b0000, 1'b0, 2'b00);

    // re-request during ack re-arms the bit
    req = 4'b0100;
    step(); chk_all("rearm_cap", 4'b0100, 1'b0, 2'b00);
    req = 4'b0000;
    step(); chk_all("rearm_g", 4'b0100, 1'b1, 2'b10);
    ack = 1'b1; req = 4'b0100;
    step(); chk_all("rearm_ack", 4'b0100, 1'b0, 2'b10);
    ack = 1'b0; req = 4'b0000;
    step(); chk_all("rearm_regrant", 4'b0100, 1'b1, 2'b10);

    // reset while in HOLD with pending 0110
    req = 4'b0010;
    step(); chk_all("pre_rst", 4'b0110, 1'b1, 2'b10);
    req = 4'b1111; ack = 1'b1; rst = 1'b1;
    step(); chk_all("mid_rst", 4'b0000, 1'b0, 2'b00);
    rst = 1'b0; req = 4'b0000; ack = 1'b1;
    step(); chk_all("idle_ack", 4'b0000, 1'b0, 2'b00);
    ack = 1'b0;
    step(); chk_all("idle_ack2", 4'b0000, 1'b0, 2'b00);

    // en=0 still lets existing pending drain
    en = 1'b1; req = 4'b0001;
    step(); chk_all("drain_cap", 4'b0001, 1'b0, 2'b00);
    en = 1'b0; req = 4'b1111;
    step(); chk_all("drain_g", 4'b0001, 1'b1, 2'b00);
    ack = 1'b1;
    step(); chk_all("drain_ack", 4'b0000, 1'b0, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
